// File: rtl/puf_response_sequencer_pkg.sv
// Shared types and defaults for the RO PUF response sequencer.
// Define PUF_TIMEOUT_EN to enable the race watchdog.
package puf_response_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRace,
    StSample,
    StDone
  } state_e;

  localparam int unsigned RespWDef = 64;
  localparam int unsigned ChalWDef = 10;
  localparam int unsigned TieW     = 7;

`ifdef PUF_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

endpackage

// File: rtl/puf_response_sequencer_sync_2ff.sv
// Reset-free two-flop synchroniser for one asynchronous PUF status bit.
module puf_response_sequencer_sync_2ff (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_response_sequencer.sv
// Sequences clear/race/sample for RespW challenges and packs race outcomes into a response word.
// Race watchdog is present only when PUF_TIMEOUT_EN is defined (see package).
module puf_response_sequencer
  import puf_response_sequencer_pkg::*;
#(
  parameter int unsigned RespW        = RespWDef,
  parameter int unsigned ChalW        = ChalWDef,
  parameter int unsigned ChalStep     = 37,
  parameter int unsigned ClearCycles  = 8,
  parameter int unsigned SampleCycles = 4,
  parameter int unsigned TimeoutCyc   = 2**24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ChalW-1:0]  seed_chal_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [RespW-1:0]  response_o,
  output logic [TieW-1:0]   tie_count_o,
  output logic              timeout_err_o,
  output logic [63:0]       puf_enable_o,
  output logic [ChalW-1:0]  puf_challenge_o,
  output logic              puf_clear_o,
  input  logic              puf_cnt1_gt_i,
  input  logic              puf_cnt2_gt_i,
  input  logic              puf_fin1_i,
  input  logic              puf_fin2_i
);

  localparam int unsigned KW = $clog2(RespW);

  logic gt1_s, gt2_s, fin1_s, fin2_s;

  puf_response_sequencer_sync_2ff u_sync_gt1 (.clk_i(clk_i), .d_i(puf_cnt1_gt_i), .q_o(gt1_s));
  puf_response_sequencer_sync_2ff u_sync_gt2 (.clk_i(clk_i), .d_i(puf_cnt2_gt_i), .q_o(gt2_s));
  puf_response_sequencer_sync_2ff u_sync_fn1 (.clk_i(clk_i), .d_i(puf_fin1_i),    .q_o(fin1_s));
  puf_response_sequencer_sync_2ff u_sync_fn2 (.clk_i(clk_i), .d_i(puf_fin2_i),    .q_o(fin2_s));

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [ChalW-1:0]   chal_q, chal_d;
  logic [RespW-1:0]   resp_q, resp_d;
  logic [TieW-1:0]    tie_q, tie_d;
  logic               tout_q, tout_d;
  logic               tbit_q, tbit_d;  // current race ended by watchdog

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
      tout_q  <= 1'b0;
      tbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      tout_q  <= tout_d;
      tbit_q  <= tbit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    chal_d       = chal_q;
    resp_d       = resp_q;
    tie_d        = tie_q;
    tout_d       = tout_q;
    tbit_d       = tbit_q;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    puf_enable_o = '0;
    puf_clear_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_o      = 1'b0;
        puf_clear_o = 1'b1;
        if (start_i) begin
          chal_d  = seed_chal_i;
          k_d     = '0;
          tie_d   = '0;
          resp_d  = '0;
          cnt_d   = '0;
          tbit_d  = 1'b0;
          state_d = StClear;
        end
      end
      StClear: begin
        puf_clear_o = 1'b1;
        if (cnt_q == ClearCycles - 1) begin
          cnt_d   = '0;
          tbit_d  = 1'b0;
          state_d = StRace;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRace: begin
        puf_enable_o = '1;
        if (fin1_s || fin2_s) begin
          cnt_d   = '0;
          state_d = StSample;
        end else if (TimeoutEn && (cnt_q == TimeoutCyc - 1)) begin
          tout_d  = 1'b1;
          tbit_d  = 1'b1;
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StSample: begin
        if (cnt_q == SampleCycles - 1) begin
          cnt_d     = '0;
          // Tie and glitch (both set) both resolve to 0.
          resp_d[k_q] = gt1_s && !gt2_s && !tbit_q;
          if (!tbit_q && !gt1_s && !gt2_s && (tie_q != TieW'(RespW))) begin
            tie_d = tie_q + 1'b1;
          end
          chal_d = chal_q + ChalW'(ChalStep);
          if (k_q == KW'(RespW - 1)) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = StClear;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        busy_o      = 1'b0;
        done_o      = 1'b1;
        puf_clear_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign response_o      = resp_q;
  assign tie_count_o     = tie_q;
  assign timeout_err_o   = tout_q;
  assign puf_challenge_o = chal_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Directed bench for puf_response_sequencer with a simple behavioural RO PUF model.
// Build with PUF_TIMEOUT_EN to exercise the watchdog path.
module tb_puf_response_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  seed_chal;
  logic        busy, done;
  logic [63:0] response;
  logic [6:0]  tie_count;
  logic        timeout_err;
  logic [63:0] puf_enable;
  logic [9:0]  puf_challenge;
  logic        puf_clear;
  logic        cnt1_gt, cnt2_gt, fin1, fin2;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  logic [7:0] race_cnt;

  puf_response_sequencer #(
    .TimeoutCyc (100)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .seed_chal_i     (seed_chal),
    .busy_o          (busy),
    .done_o          (done),
    .response_o      (response),
    .tie_count_o     (tie_count),
    .timeout_err_o   (timeout_err),
    .puf_enable_o    (puf_enable),
    .puf_challenge_o (puf_challenge),
    .puf_clear_o     (puf_clear),
    .puf_cnt1_gt_i   (cnt1_gt),
    .puf_cnt2_gt_i   (cnt2_gt),
    .puf_fin1_i      (fin1),
    .puf_fin2_i      (fin2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PUF model: counter1 finishes 3 cycles into the race; compare result set by mode.
  always @(posedge clk) begin
    if (puf_clear) race_cnt <= 8'd0;
    else if ((&puf_enable) && race_cnt != 8'hFF) race_cnt <= race_cnt + 8'd1;
  end

  always_comb begin
    fin1    = (mode != 3) && (race_cnt >= 8'd3);
    fin2    = 1'b0;
    cnt1_gt = 1'b1;
    cnt2_gt = 1'b0;
    case (mode)
      1: begin
        cnt1_gt = ^puf_challenge;
        cnt2_gt = ~(^puf_challenge);
      end
      2: begin
        // Challenges 0,37,74,111,148 are bits 0..4 for seed 0.
        if (puf_challenge < 10'd150 && (puf_challenge % 10'd37) == 10'd0) begin
          cnt1_gt = 1'b0;
          cnt2_gt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [9:0] seed);
    @(negedge clk);
    seed_chal = seed;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [63:0] exp_par;
  logic [9:0]  c;
  bit          ok;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    seed_chal = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_resp", response, 64'd0);
    chk("rst_tie", tie_count, 7'd0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_en", puf_enable, 64'd0);
    chk("rst_chal", puf_challenge, 10'd0);
    chk("rst_clear", puf_clear, 1'b1);
    rst_n = 1'b1;

    // All ones: counter1 always wins.
    mode = 0;
    start_run(10'd0);
    chk("t2_busy", busy, 1'b1);
    wait_done(5000, ok);
    chk("t2_done_seen", ok, 1'b1);
    chk("t2_busy_in_done", busy, 1'b0);
    chk("t2_resp", response, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_tie", tie_count, 7'd0);
    @(negedge clk);
    chk("t2_done_pulse", done, 1'b0);
    chk("t2_chal_end", puf_challenge, 10'h140);
    chk("t2_idle_clear", puf_clear, 1'b1);

    // Parity of challenge, wrapping challenge sequence from 3FF.
    mode = 1;
    for (int k = 0; k < 64; k++) begin
      c = 10'h3FF + 10'(37 * k);
      exp_par[k] = ^c;
    end
    start_run(10'h3FF);
    chk("t3_chal0", puf_challenge, 10'h3FF);
    chk("t3_clear", puf_clear, 1'b1);
    chk("t3_en_off", puf_enable, 64'd0);
    wait_done(5000, ok);
    chk("t3_done_seen", ok, 1'b1);
    chk("t3_resp", response, exp_par);
    chk("t3_tie", tie_count, 7'd0);
    @(negedge clk);
    chk("t3_chal_end", puf_challenge, 10'h13F);

    // Ties on bits 0..4.
    mode = 2;
    start_run(10'd0);
    wait_done(5000, ok);
    chk("t4_done_seen", ok, 1'b1);
    chk("t4_resp", response, 64'hFFFF_FFFF_FFFF_FFE0);
    chk("t4_tie", tie_count, 7'd5);

    // Reset while racing bit 10.
    mode = 0;
    start_run(10'd0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (puf_challenge == 10'd370 && (&puf_enable)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t1_reached_bit10", ok, 1'b1);
    chk("t1_partial_resp", response, 64'h3FF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t1_busy", busy, 1'b0);
    chk("t1_en", puf_enable, 64'd0);
    chk("t1_clear", puf_clear, 1'b1);
    chk("t1_resp", response, 64'd0);
    rst_n = 1'b1;

    // start held high through the whole run and the DONE cycle.
    @(negedge clk);
    seed_chal = 10'd5;
    start     = 1'b1;
    @(negedge clk);
    wait_done(5000, ok);
    chk("t5_done_seen", ok, 1'b1);
    chk("t5_busy_in_done", busy, 1'b0);
    @(negedge clk);
    chk("t5_no_done_repeat", done, 1'b0);
    chk("t5_idle_not_busy", busy, 1'b0);
    @(negedge clk);
    chk("t5_restart_busy", busy, 1'b1);
    chk("t5_restart_chal", puf_challenge, 10'd5);
    start = 1'b0;
    do_reset();

    // Races never finish.
    mode = 3;
    start_run(10'd0);
`ifdef PUF_TIMEOUT_EN
    wait_done(20000, ok);
    chk("t6_done_seen", ok, 1'b1);
    chk("t6_terr", timeout_err, 1'b1);
    chk("t6_resp", response, 64'd0);
    chk("t6_tie", tie_count, 7'd0);
`else
    repeat (400) @(negedge clk);
    chk("t6_busy_stuck", busy, 1'b1);
    chk("t6_en_racing", puf_enable, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_terr", timeout_err, 1'b0);
    chk("t6_no_done", done, 1'b0);
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
